// File: rtl/fifo_reader_tx.sv
// rtl/fifo_reader_tx.sv - pops one FIFO word per frame and sends it as a start/data/stop serial frame
module fifo_reader_tx #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic                  rd_val,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [CNT_W-1:0]      cyc_cnt;
    logic [CNT_W-1:0]      cyc_nx;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_nx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nx;
    logic                  rd_en_nx;
    logic                  tx_nx;
    // Blocks a pop on the first edge after reset release so the FIFO sees a clean cycle.
    logic                  armed;

    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && (cyc_cnt == CNT_LAST);

    // Next-state and next-output logic; the payload is shifted right so tx always takes bit 0.
    always_comb begin
        state_nx = state;
        cyc_nx   = cyc_cnt;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        rd_en_nx = 1'b0;
        tx_nx    = tx;
        case (state)
            IDLE: begin
                tx_nx  = 1'b1;
                cyc_nx = '0;
                bit_nx = '0;
                if (armed && rd_val && tx_en) begin
                    rd_en_nx = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                state_nx = WAIT;
            end
            WAIT: begin
                shreg_nx = rd_data;
                tx_nx    = 1'b0;
                cyc_nx   = '0;
                state_nx = START;
            end
            START: begin
                if (cyc_cnt == CNT_LAST) begin
                    cyc_nx   = '0;
                    bit_nx   = '0;
                    tx_nx    = shreg[0];
                    shreg_nx = shreg >> 1;
                    state_nx = DATA;
                end else begin
                    cyc_nx = cyc_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cyc_cnt == CNT_LAST) begin
                    cyc_nx = '0;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nx   = '0;
                        tx_nx    = 1'b1;
                        state_nx = STOP;
                    end else begin
                        bit_nx   = bit_cnt + BIT_W'(1);
                        tx_nx    = shreg[0];
                        shreg_nx = shreg >> 1;
                    end
                end else begin
                    cyc_nx = cyc_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                tx_nx = 1'b1;
                if (cyc_cnt == CNT_LAST) begin
                    cyc_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cyc_nx = cyc_cnt + CNT_W'(1);
                end
            end
            default: begin
                tx_nx    = 1'b1;
                cyc_nx   = '0;
                bit_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any frame in flight together with its word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            rd_en   <= 1'b0;
            tx      <= 1'b1;
            armed   <= 1'b0;
        end else begin
            state   <= state_nx;
            cyc_cnt <= cyc_nx;
            bit_cnt <= bit_nx;
            shreg   <= shreg_nx;
            rd_en   <= rd_en_nx;
            tx      <= tx_nx;
            armed   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_reader_tx.sv
// tb/tb_fifo_reader_tx.sv - scoreboard bench for fifo_reader_tx
module tb_fifo_reader_tx;

    localparam int DW        = 4;
    localparam int CPB       = 4;
    localparam int FRAME_LEN = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_en;
    logic          rd_val;
    logic [DW-1:0] rd_data;
    logic          rd_en;
    logic          tx;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    fifo_reader_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .rd_val     (rd_val),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            gaps[$];

    int  cyc_no = 0;
    int  rd_en_cnt, fd_cnt, frames_seen;
    int  first_rd_cyc, first_fall_cyc;
    bit  tx_low_seen, busy_seen;
    bit  scramble    = 1'b0;
    bit  popped_last = 1'b0;
    bit  in_frame    = 1'b0;
    int  fcyc        = 0;
    int  hi_run      = 0;
    logic [FRAME_LEN-1:0] cap;

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        rd_val = 1'b1;
    endtask

    task automatic clear_counts();
        rd_en_cnt      = 0;
        fd_cnt         = 0;
        frames_seen    = 0;
        first_rd_cyc   = -1;
        first_fall_cyc = -1;
        tx_low_seen    = 1'b0;
        busy_seen      = 1'b0;
        gaps.delete();
    endtask

    // One clock: FIFO model reacts to rd_en, then the serial monitor decodes tx into the scoreboard.
    task automatic step();
        logic [DW-1:0] word;
        logic [DW-1:0] expw;
        bit            ok;
        @(posedge clk);
        #1;
        cyc_no++;
        if (rd_en) begin
            n_cmp++;
            if (fifo_q.size() == 0) begin
                n_fail++;
                $display("FAIL fifo_underflow: rd_en=1 with empty fifo at cycle %0d", cyc_no);
            end else begin
                rd_data = fifo_q.pop_front();
            end
            popped_last = 1'b1;
        end else begin
            if (scramble && !popped_last) rd_data = ~rd_data;
            popped_last = 1'b0;
        end
        rd_val = (fifo_q.size() != 0);

        if (rd_en) begin
            rd_en_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc_no;
        end
        if (frame_done) fd_cnt++;
        if (!tx)        tx_low_seen = 1'b1;
        if (busy)       busy_seen = 1'b1;

        if (!in_frame && !tx) begin
            in_frame = 1'b1;
            fcyc     = 0;
            gaps.push_back(hi_run);
            if (first_fall_cyc < 0) first_fall_cyc = cyc_no;
        end
        if (tx) hi_run++;
        else    hi_run = 0;

        if (!in_frame) begin
            n_cmp++;
            if (frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_done_idle: got %b required 0 at cycle %0d", frame_done, cyc_no);
            end
        end else begin
            cap[fcyc] = tx;
            n_cmp++;
            if (frame_done !== (fcyc == FRAME_LEN - 1)) begin
                n_fail++;
                $display("FAIL frame_done_pos: got %b at frame cycle %0d", frame_done, fcyc);
            end
            if (fcyc == FRAME_LEN - 1) begin
                ok = 1'b1;
                for (int b = 0; b < DW + 2; b++)
                    for (int c = 1; c < CPB; c++)
                        if (cap[b*CPB+c] !== cap[b*CPB]) ok = 1'b0;
                if (cap[0] !== 1'b0) ok = 1'b0;
                if (cap[(DW+1)*CPB] !== 1'b1) ok = 1'b0;
                for (int k = 0; k < DW; k++) word[k] = cap[(k+1)*CPB];
                n_cmp++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL frame_shape: captured %b", cap);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_unexpected: got word %h with empty scoreboard", word);
                end else begin
                    expw = exp_q.pop_front();
                    if (word !== expw) begin
                        n_fail++;
                        $display("FAIL frame_data: got %b required %b", word, expw);
                    end
                end
                frames_seen++;
                in_frame = 1'b0;
            end else begin
                fcyc++;
            end
        end
    endtask

    task automatic run_until_idle(input int max, input string name);
        int n;
        for (n = 0; n < max; n++) begin
            step();
            if (exp_q.size() == 0 && busy == 1'b0 && !in_frame) break;
        end
        n_cmp++;
        if (!(exp_q.size() == 0 && busy == 1'b0 && !in_frame)) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d words outstanding after %0d cycles", name, exp_q.size(), max);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        tx_en   = 1'b0;
        rd_val  = 1'b0;
        rd_data = '0;
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
        n_cmp++; if (rd_en !== 1'b0)      begin n_fail++; $display("FAIL reset_rd_en: got %b required 0", rd_en); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
        push_word(4'b0011);
        tx_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_hold_rd_en: got %b required 0", rd_en); end
        @(negedge clk);
        reset = 1'b1;
        clear_counts();
        step();
        n_cmp++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL release_edge1_rd_en: got %b required 0", rd_en); end
        step();
        n_cmp++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL release_edge2_rd_en: got %b required 1", rd_en); end
        run_until_idle(100, "reset_frame");
        n_cmp++; if (rd_en_cnt != 1) begin n_fail++; $display("FAIL reset_frame_pops: got %0d required 1", rd_en_cnt); end
    endtask

    task automatic test_single();
        logic [FRAME_LEN-1:0] pat;
        bit                   seqv [6];
        seqv = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < FRAME_LEN; i++) pat[i] = seqv[i / CPB];
        clear_counts();
        tx_en = 1'b1;
        push_word(4'b1011);
        run_until_idle(100, "single");
        n_cmp++; if (rd_en_cnt != 1)   begin n_fail++; $display("FAIL single_pops: got %0d required 1", rd_en_cnt); end
        n_cmp++; if (fd_cnt != 1)      begin n_fail++; $display("FAIL single_frame_done: got %0d required 1", fd_cnt); end
        n_cmp++; if (frames_seen != 1) begin n_fail++; $display("FAIL single_frames: got %0d required 1", frames_seen); end
        n_cmp++; if (cap !== pat)      begin n_fail++; $display("FAIL single_pattern: got %b required %b", cap, pat); end
        n_cmp++;
        if (first_fall_cyc - first_rd_cyc != 2) begin
            n_fail++;
            $display("FAIL single_latency: got %0d required 2", first_fall_cyc - first_rd_cyc);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        tx_en = 1'b1;
        push_word(4'd7);
        push_word(4'd6);
        push_word(4'd5);
        run_until_idle(300, "b2b");
        n_cmp++; if (rd_en_cnt != 3)   begin n_fail++; $display("FAIL b2b_pops: got %0d required 3", rd_en_cnt); end
        n_cmp++; if (frames_seen != 3) begin n_fail++; $display("FAIL b2b_frames: got %0d required 3", frames_seen); end
        n_cmp++;
        if (gaps.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_gap_count: got %0d required 3", gaps.size());
        end else if (gaps[1] != CPB + 3 || gaps[2] != CPB + 3) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d,%0d required %0d", gaps[1], gaps[2], CPB + 3);
        end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_flow_control();
        int n;
        clear_counts();
        tx_en = 1'b0;
        push_word(4'b1100);
        repeat (20) step();
        n_cmp++; if (rd_en_cnt != 0)     begin n_fail++; $display("FAIL flow_hold_pops: got %0d required 0", rd_en_cnt); end
        n_cmp++; if (tx_low_seen != 1'b0) begin n_fail++; $display("FAIL flow_hold_tx: got low required high"); end
        n_cmp++; if (busy_seen != 1'b0)   begin n_fail++; $display("FAIL flow_hold_busy: got 1 required 0"); end
        push_word(4'b0010);
        tx_en = 1'b1;
        for (n = 0; n < 10 && !in_frame; n++) step();
        tx_en = 1'b0;
        for (n = 0; n < 40 && in_frame; n++) step();
        repeat (30) step();
        n_cmp++; if (frames_seen != 1) begin n_fail++; $display("FAIL flow_frames: got %0d required 1", frames_seen); end
        n_cmp++; if (rd_en_cnt != 1)   begin n_fail++; $display("FAIL flow_pops: got %0d required 1", rd_en_cnt); end
        n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL flow_busy: got %b required 0", busy); end
        tx_en = 1'b1;
        run_until_idle(100, "flow_drain");
        n_cmp++; if (frames_seen != 2) begin n_fail++; $display("FAIL flow_drain_frames: got %0d required 2", frames_seen); end
    endtask

    task automatic test_data_stability();
        clear_counts();
        tx_en    = 1'b1;
        scramble = 1'b1;
        push_word(4'b1001);
        push_word(4'b0110);
        run_until_idle(200, "stability");
        scramble = 1'b0;
        n_cmp++; if (frames_seen != 2) begin n_fail++; $display("FAIL stability_frames: got %0d required 2", frames_seen); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        clear_counts();
        tx_en = 1'b1;
        push_word(4'b1110);
        for (n = 0; n < 10 && !in_frame; n++) step();
        n_cmp++; if (!in_frame) begin n_fail++; $display("FAIL midrst_start: got no frame required frame within 10 cycles"); end
        repeat (CPB + CPB + 1) step();
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1)    begin n_fail++; $display("FAIL midrst_tx: got %b required 1", tx); end
        n_cmp++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL midrst_rd_en: got %b required 0", rd_en); end
        n_cmp++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        in_frame = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_counts();
        repeat (10) step();
        n_cmp++; if (rd_en_cnt != 0)   begin n_fail++; $display("FAIL midrst_no_pop: got %0d required 0", rd_en_cnt); end
        n_cmp++; if (busy_seen != 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy required idle"); end
        push_word(4'b0101);
        run_until_idle(100, "midrst");
        n_cmp++; if (frames_seen != 1) begin n_fail++; $display("FAIL midrst_frames: got %0d required 1", frames_seen); end
    endtask

    task automatic test_empty();
        clear_counts();
        tx_en = 1'b1;
        repeat (40) step();
        n_cmp++; if (rd_en_cnt != 0)     begin n_fail++; $display("FAIL empty_pops: got %0d required 0", rd_en_cnt); end
        n_cmp++; if (tx_low_seen != 1'b0) begin n_fail++; $display("FAIL empty_tx: got low required high"); end
        n_cmp++; if (busy_seen != 1'b0)   begin n_fail++; $display("FAIL empty_busy: got 1 required 0"); end
        n_cmp++; if (fd_cnt != 0)        begin n_fail++; $display("FAIL empty_frame_done: got %0d required 0", fd_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flow_control();
        test_data_stability();
        test_reset_mid_frame();
        test_empty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
